// File: rtl/sh7604_pkg.sv
// SH7604 shared types: bus arbiter debug state codes and float-cycle limits.
package sh7604_pkg;

  typedef logic [2:0] arb_st_t;

  localparam arb_st_t ARB_IDLE  = 3'd0;
  localparam arb_st_t ARB_INT   = 3'd1;
  localparam arb_st_t ARB_HOLD  = 3'd2;
  localparam arb_st_t ARB_FLT_E = 3'd3;
  localparam arb_st_t ARB_EXT   = 3'd4;
  localparam arb_st_t ARB_FLT_I = 3'd5;

  localparam int FLOAT_CYC_MIN = 1;
  localparam int FLOAT_CYC_MAX = 7;
  localparam int BURST_BEATS   = 4;

  // Out-of-range parameters are clamped so the float counter can never load 0.
  function automatic logic [2:0] float_load(input int cyc);
    if (cyc < FLOAT_CYC_MIN) return 3'(FLOAT_CYC_MIN);
    if (cyc > FLOAT_CYC_MAX) return 3'(FLOAT_CYC_MAX);
    return 3'(cyc);
  endfunction

endpackage

// File: rtl/sh7604_bus_arb.sv
// Bus ownership arbiter between the internal DBUS master and an external BRLS/BGR master.
// Grant to the internal master takes 1 CE_R; external grant takes 2 (sync) + 1 + FLOAT_CYC CE_R.
module sh7604_bus_arb
  import sh7604_pkg::*;
#(
  parameter int FLOAT_CYC = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE_R,
  input  logic       CE_F,
  input  logic       EN,
  input  logic       INT_REQ,
  input  logic       INT_LOCK,
  input  logic       INT_BURST,
  input  logic       BUS_RDY,
  input  logic       BRLS_N,
  output logic       BGR_N,
  output logic       INT_GNT,
  output logic       INT_WAIT,
  output logic       BUS_HIZ,
  output logic [2:0] ARB_ST
);

  localparam logic [2:0] FLT_LOAD  = float_load(FLOAT_CYC);
  localparam logic [1:0] BEAT_LOAD = 2'(BURST_BEATS - 1);

  logic       brls_s1_q;
  logic       brls_s2_q;
  arb_st_t    st_q;
  arb_st_t    st_d;
  logic [1:0] beat_q;
  logic [1:0] beat_d;
  logic [2:0] flt_q;
  logic [2:0] flt_d;
  logic       ext_req;
  logic       ext_pending;
  logic       adv;
  logic       gnt;
  logic       unused_ce_f;

  assign unused_ce_f = CE_F;
  assign adv         = CE_R & EN;
  assign ext_req     = ~brls_s2_q;
  // A request still travelling through the synchroniser keeps an idle bus parked,
  // so an external request that arrives together with INT_REQ still wins.
  assign ext_pending = ~(BRLS_N & brls_s1_q & brls_s2_q);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      brls_s1_q <= 1'b1;
      brls_s2_q <= 1'b1;
    end else if (CE_R) begin
      brls_s1_q <= BRLS_N;
      brls_s2_q <= brls_s1_q;
    end
  end

  always_comb begin
    st_d   = st_q;
    beat_d = beat_q;
    flt_d  = flt_q;
    case (st_q)
      ARB_IDLE: begin
        if (ext_req) begin
          st_d  = ARB_FLT_E;
          flt_d = FLT_LOAD;
        end else if (INT_REQ && !ext_pending) begin
          st_d = ARB_INT;
        end
      end
      ARB_INT: begin
        if (INT_REQ && (INT_BURST || INT_LOCK)) begin
          st_d   = ARB_HOLD;
          beat_d = INT_BURST ? BEAT_LOAD : 2'd0;
        end else if (ext_req) begin
          st_d  = ARB_FLT_E;
          flt_d = FLT_LOAD;
        end else if (!INT_REQ) begin
          st_d = ARB_IDLE;
        end
      end
      ARB_HOLD: begin
        if (BUS_RDY) begin
          if (beat_q != 2'd0) begin
            beat_d = beat_q - 2'd1;
          end else if (!INT_LOCK) begin
            st_d = ARB_INT;
          end
        end
      end
      ARB_FLT_E: begin
        if (!ext_req) begin
          st_d  = ARB_FLT_I;
          flt_d = FLT_LOAD;
        end else if (flt_q <= 3'd1) begin
          st_d  = ARB_EXT;
          flt_d = 3'd0;
        end else begin
          flt_d = flt_q - 3'd1;
        end
      end
      ARB_EXT: begin
        if (!ext_req) begin
          st_d  = ARB_FLT_I;
          flt_d = FLT_LOAD;
        end
      end
      ARB_FLT_I: begin
        if (flt_q <= 3'd1) begin
          st_d  = INT_REQ ? ARB_INT : ARB_IDLE;
          flt_d = 3'd0;
        end else begin
          flt_d = flt_q - 3'd1;
        end
      end
      default: begin
        st_d   = ARB_IDLE;
        beat_d = 2'd0;
        flt_d  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_q   <= ARB_IDLE;
      beat_q <= 2'd0;
      flt_q  <= 3'd0;
    end else if (adv) begin
      st_q   <= st_d;
      beat_q <= beat_d;
      flt_q  <= flt_d;
    end
  end

  // Outputs decode the registered state only, so reset clears them without a clock.
  assign gnt      = (st_q == ARB_INT) | (st_q == ARB_HOLD);
  assign INT_GNT  = gnt;
  assign BGR_N    = ~(st_q == ARB_EXT);
  assign BUS_HIZ  = (st_q == ARB_FLT_E) | (st_q == ARB_FLT_I) | (st_q == ARB_EXT);
  assign INT_WAIT = RST_N & INT_REQ & ~gnt;
  assign ARB_ST   = st_q;

endmodule

// File: tb/tb_sh7604_bus_arb.sv
// Bench for sh7604_bus_arb: directed ownership scenarios plus a randomized run against an owner/float model.
module tb_sh7604_bus_arb;
  import sh7604_pkg::*;

  localparam int FC = 2;

  logic       CLK = 1'b0;
  logic       RST_N, CE_R, CE_F, EN;
  logic       INT_REQ, INT_LOCK, INT_BURST, BUS_RDY, BRLS_N;
  logic       BGR_N, INT_GNT, INT_WAIT, BUS_HIZ;
  logic [2:0] ARB_ST;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  sh7604_bus_arb #(.FLOAT_CYC(FC)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .EN(EN),
    .INT_REQ(INT_REQ), .INT_LOCK(INT_LOCK), .INT_BURST(INT_BURST),
    .BUS_RDY(BUS_RDY), .BRLS_N(BRLS_N), .BGR_N(BGR_N), .INT_GNT(INT_GNT),
    .INT_WAIT(INT_WAIT), .BUS_HIZ(BUS_HIZ), .ARB_ST(ARB_ST)
  );

  // Reference model: who owns the bus (0 nobody, 1 cpu, 2 external), beats still
  // owed by a burst/lock, and remaining float cycles with their destination.
  int         m_owner = 0;
  int         m_beats_left = 0;
  int         m_float_left = 0;
  int         m_float_to = 0;
  logic       m_s1 = 1'b1, m_s2 = 1'b1, m_ext = 1'b0;
  logic       e_gnt = 1'b0, e_bgr_n = 1'b1, e_hiz = 1'b0;
  logic [2:0] e_st = ARB_IDLE;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_owner = 0; m_beats_left = 0; m_float_left = 0; m_float_to = 0;
    end else if (CE_R) begin
      m_ext = !m_s2;
      if (EN) begin
        if (m_float_left > 0) begin
          if (m_float_to == 2 && !m_ext) begin
            m_float_to = 1; m_float_left = FC;
          end else begin
            m_float_left = m_float_left - 1;
            if (m_float_left == 0) m_owner = (m_float_to == 2) ? 2 : (INT_REQ ? 1 : 0);
          end
        end else if (m_owner == 2) begin
          if (!m_ext) begin m_owner = 0; m_float_to = 1; m_float_left = FC; end
        end else if (m_owner == 1 && m_beats_left > 0) begin
          if (BUS_RDY) begin
            if (m_beats_left > 1) m_beats_left = m_beats_left - 1;
            else if (!INT_LOCK) m_beats_left = 0;
          end
        end else if (m_owner == 1) begin
          if (INT_REQ && (INT_BURST || INT_LOCK)) m_beats_left = INT_BURST ? 4 : 1;
          else if (m_ext) begin m_owner = 0; m_float_to = 2; m_float_left = FC; end
          else if (!INT_REQ) m_owner = 0;
        end else begin
          if (m_ext) begin m_float_to = 2; m_float_left = FC; end
          else if (INT_REQ && BRLS_N && m_s1 && m_s2) m_owner = 1;
        end
      end
      m_s2 = m_s1;
      m_s1 = BRLS_N;
    end
    e_gnt   = (m_owner == 1) && (m_float_left == 0);
    e_bgr_n = !(m_owner == 2);
    e_hiz   = (m_float_left > 0) || (m_owner == 2);
    if (m_float_left > 0)      e_st = (m_float_to == 2) ? ARB_FLT_E : ARB_FLT_I;
    else if (m_owner == 2)     e_st = ARB_EXT;
    else if (m_owner == 1)     e_st = (m_beats_left > 0) ? ARB_HOLD : ARB_INT;
    else                       e_st = ARB_IDLE;
  end

  // Grants must never overlap, and nobody is granted while the bus floats.
  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      n_cmp++;
      if ((INT_GNT && !BGR_N) ||
          ((ARB_ST == ARB_FLT_E || ARB_ST == ARB_FLT_I) && (INT_GNT || !BGR_N))) begin
        n_err++;
        $display("FAIL grant_exclusive: st=%0d INT_GNT=%b BGR_N=%b, want no overlap", ARB_ST, INT_GNT, BGR_N);
      end
    end
  end

  task automatic go_idle();
    @(negedge CLK);
    CE_R = 1'b1; CE_F = 1'b0; EN = 1'b1;
    INT_REQ = 1'b0; INT_LOCK = 1'b0; INT_BURST = 1'b0; BUS_RDY = 1'b0; BRLS_N = 1'b1;
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST_N = 1'b0; CE_R = 1'b1; CE_F = 1'b0; EN = 1'b1;
    INT_REQ = 1'b1; INT_LOCK = 1'b0; INT_BURST = 1'b0; BUS_RDY = 1'b0; BRLS_N = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++; if (ARB_ST !== ARB_IDLE) begin n_err++; $display("FAIL reset_st: got %0d want %0d", ARB_ST, ARB_IDLE); end
    n_cmp++; if (BGR_N !== 1'b1) begin n_err++; $display("FAIL reset_bgr: got %b want 1", BGR_N); end
    n_cmp++; if (INT_GNT !== 1'b0) begin n_err++; $display("FAIL reset_gnt: got %b want 0", INT_GNT); end
    n_cmp++; if (INT_WAIT !== 1'b0) begin n_err++; $display("FAIL reset_wait: got %b want 0", INT_WAIT); end
    n_cmp++; if (BUS_HIZ !== 1'b0) begin n_err++; $display("FAIL reset_hiz: got %b want 0", BUS_HIZ); end
    INT_REQ = 1'b0;
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_int_grant();
    go_idle();
    INT_REQ = 1'b1;
    @(negedge CLK);
    n_cmp++; if (INT_GNT !== 1'b1 || ARB_ST !== ARB_INT) begin n_err++; $display("FAIL int_grant: gnt=%b st=%0d want 1/%0d", INT_GNT, ARB_ST, ARB_INT); end
    n_cmp++; if (INT_WAIT !== 1'b0) begin n_err++; $display("FAIL int_grant_wait: got %b want 0", INT_WAIT); end
    INT_REQ = 1'b0;
    @(negedge CLK);
    n_cmp++; if (ARB_ST !== ARB_IDLE || INT_GNT !== 1'b0) begin n_err++; $display("FAIL int_release: st=%0d gnt=%b want %0d/0", ARB_ST, INT_GNT, ARB_IDLE); end
  endtask

  task automatic test_enable();
    go_idle();
    INT_REQ = 1'b1;
    @(negedge CLK);
    EN = 1'b0; INT_REQ = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      n_cmp++; if (ARB_ST !== ARB_INT) begin n_err++; $display("FAIL enable_hold: st=%0d want %0d", ARB_ST, ARB_INT); end
    end
    EN = 1'b1;
    @(negedge CLK);
    n_cmp++; if (ARB_ST !== ARB_IDLE) begin n_err++; $display("FAIL enable_resume: st=%0d want %0d", ARB_ST, ARB_IDLE); end
  endtask

  task automatic test_burst();
    int flt;
    bit seen;
    go_idle();
    INT_REQ = 1'b1;
    @(negedge CLK);
    INT_BURST = 1'b1; BRLS_N = 1'b0;
    @(negedge CLK);
    INT_BURST = 1'b0;
    n_cmp++; if (ARB_ST !== ARB_HOLD) begin n_err++; $display("FAIL burst_hold: st=%0d want %0d", ARB_ST, ARB_HOLD); end
    for (int b = 0; b < 4; b++) begin
      BUS_RDY = 1'b0;
      repeat (1 + $urandom_range(0, 2)) begin
        @(negedge CLK);
        n_cmp++; if (INT_GNT !== 1'b1 || BGR_N !== 1'b1) begin n_err++; $display("FAIL burst_gap%0d: gnt=%b bgr_n=%b want 1/1", b, INT_GNT, BGR_N); end
      end
      BUS_RDY = 1'b1;
      @(negedge CLK);
      n_cmp++; if (INT_GNT !== 1'b1 || ARB_ST !== ((b < 3) ? ARB_HOLD : ARB_INT)) begin
        n_err++; $display("FAIL burst_beat%0d: gnt=%b st=%0d", b, INT_GNT, ARB_ST); end
    end
    BUS_RDY = 1'b0;
    flt = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (!BGR_N) seen = 1'b1;
      else if (BUS_HIZ && !INT_GNT) flt++;
    end
    n_cmp++; if (!seen || flt != FC) begin n_err++; $display("FAIL burst_float: granted=%b float_cycles=%0d want 1/%0d", seen, flt, FC); end
  endtask

  task automatic test_lock();
    int n;
    bit seen;
    go_idle();
    INT_REQ = 1'b1;
    @(negedge CLK);
    INT_LOCK = 1'b1; BRLS_N = 1'b0; BUS_RDY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      n_cmp++; if (BGR_N !== 1'b1 || INT_GNT !== 1'b1) begin n_err++; $display("FAIL lock_hold%0d: bgr_n=%b gnt=%b want 1/1", i, BGR_N, INT_GNT); end
    end
    INT_LOCK = 1'b0;
    @(negedge CLK);
    n_cmp++; if (ARB_ST !== ARB_INT) begin n_err++; $display("FAIL lock_exit: st=%0d want %0d", ARB_ST, ARB_INT); end
    n = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      n++;
      if (!BGR_N) seen = 1'b1;
    end
    n_cmp++; if (!seen || n != 1 + FC) begin n_err++; $display("FAIL lock_release_latency: granted=%b cycles=%0d want 1/%0d", seen, n, 1 + FC); end
  endtask

  task automatic test_simultaneous();
    int n;
    bit seen;
    go_idle();
    BRLS_N = 1'b0; INT_REQ = 1'b1;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      n++;
      if (!BGR_N) seen = 1'b1;
      n_cmp++; if (INT_GNT !== 1'b0 || INT_WAIT !== 1'b1) begin n_err++; $display("FAIL simul_wait%0d: gnt=%b wait=%b want 0/1", i, INT_GNT, INT_WAIT); end
    end
    n_cmp++; if (!seen || n != 3 + FC) begin n_err++; $display("FAIL simul_ext_latency: granted=%b cycles=%0d want 1/%0d", seen, n, 3 + FC); end
    repeat (3) @(negedge CLK);
    BRLS_N = 1'b1;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      n++;
      if (INT_GNT) seen = 1'b1;
      else begin
        n_cmp++; if (INT_WAIT !== 1'b1) begin n_err++; $display("FAIL simul_return_wait%0d: got %b want 1", i, INT_WAIT); end
      end
    end
    n_cmp++; if (!seen || n != 3 + FC || INT_WAIT !== 1'b0) begin
      n_err++; $display("FAIL simul_return: granted=%b cycles=%0d wait=%b want 1/%0d/0", seen, n, INT_WAIT, 3 + FC); end
  endtask

  task automatic test_abort();
    bit saw_e, saw_i, resumed;
    go_idle();
    INT_REQ = 1'b1;
    @(negedge CLK);
    BRLS_N = 1'b0;
    repeat (2) @(negedge CLK);
    BRLS_N = 1'b1;
    saw_e = 1'b0; saw_i = 1'b0; resumed = 1'b0;
    for (int i = 0; i < 12 && !resumed; i++) begin
      @(negedge CLK);
      if (ARB_ST == ARB_FLT_E) saw_e = 1'b1;
      if (ARB_ST == ARB_FLT_I) saw_i = 1'b1;
      if (INT_GNT && saw_i) resumed = 1'b1;
      n_cmp++; if (BGR_N !== 1'b1) begin n_err++; $display("FAIL abort_no_grant%0d: bgr_n=%b want 1", i, BGR_N); end
    end
    n_cmp++; if (!(saw_e && saw_i && resumed)) begin n_err++; $display("FAIL abort_path: flt_e=%b flt_i=%b resumed=%b want 1/1/1", saw_e, saw_i, resumed); end
  endtask

  task automatic test_reset_ext();
    int n;
    bit seen;
    go_idle();
    BRLS_N = 1'b0;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      n++;
      if (!BGR_N) seen = 1'b1;
    end
    n_cmp++; if (!seen || n != 3 + FC) begin n_err++; $display("FAIL ext_latency: granted=%b cycles=%0d want 1/%0d", seen, n, 3 + FC); end
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    n_cmp++; if (BGR_N !== 1'b1 || BUS_HIZ !== 1'b0) begin n_err++; $display("FAIL async_reset_ext: bgr_n=%b hiz=%b want 1/0", BGR_N, BUS_HIZ); end
    n_cmp++; if (ARB_ST !== ARB_IDLE || INT_GNT !== 1'b0) begin n_err++; $display("FAIL async_reset_st: st=%0d gnt=%b want %0d/0", ARB_ST, INT_GNT, ARB_IDLE); end
    BRLS_N = 1'b1;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_random();
    go_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      n_cmp++; if (ARB_ST !== e_st) begin n_err++; $display("FAIL rnd_st@%0d: got %0d want %0d", i, ARB_ST, e_st); end
      n_cmp++; if (INT_GNT !== e_gnt) begin n_err++; $display("FAIL rnd_gnt@%0d: got %b want %b", i, INT_GNT, e_gnt); end
      n_cmp++; if (BGR_N !== e_bgr_n) begin n_err++; $display("FAIL rnd_bgr@%0d: got %b want %b", i, BGR_N, e_bgr_n); end
      n_cmp++; if (BUS_HIZ !== e_hiz) begin n_err++; $display("FAIL rnd_hiz@%0d: got %b want %b", i, BUS_HIZ, e_hiz); end
      n_cmp++; if (INT_WAIT !== (INT_REQ && !e_gnt)) begin n_err++; $display("FAIL rnd_wait@%0d: got %b want %b", i, INT_WAIT, INT_REQ && !e_gnt); end
      CE_R = ($urandom_range(0, 9) != 0);
      CE_F = ~CE_R;
      EN = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 7) == 0) INT_REQ = ~INT_REQ;
      if ($urandom_range(0, 15) == 0) INT_LOCK = ~INT_LOCK;
      INT_BURST = ($urandom_range(0, 5) == 0);
      BUS_RDY = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 11) == 0) BRLS_N = ~BRLS_N;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_int_grant();
    test_enable();
    test_burst();
    test_lock();
    test_simultaneous();
    test_abort();
    test_reset_ext();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
